us_event_timer: RTL

//   Programmable interval timer counting 1 us ticks from the 1 us tick generator (one-cycle

---
 rtl/us_event_timer_if.sv | 27 ++
 rtl/us_event_timer.sv | 96 +++++++++
 2 files changed

// File: rtl/us_event_timer_if.sv
// Control/status bundle for us_event_timer: timing pulses and configuration in,
// busy/expiry/sticky flags and the remaining count out.
interface us_event_timer_if #(
  parameter int WIDTH = 24
);
  logic             i_tick_1us;
  logic             i_start;
  logic             i_stop;
  logic             i_periodic;
  logic [WIDTH-1:0] i_period;
  logic             i_ack;
  logic             o_busy;
  logic             o_expired;
  logic             o_pending;
  logic             o_overrun;
  logic [WIDTH-1:0] o_remaining;

  modport master (
    output i_tick_1us, i_start, i_stop, i_periodic, i_period, i_ack,
    input  o_busy, o_expired, o_pending, o_overrun, o_remaining
  );

  modport slave (
    input  i_tick_1us, i_start, i_stop, i_periodic, i_period, i_ack,
    output o_busy, o_expired, o_pending, o_overrun, o_remaining
  );
endinterface

// File: rtl/us_event_timer.sv
// One-shot / periodic interval timer counting 1 us ticks, with sticky pending and
// overrun flags for the consumer to acknowledge.
module us_event_timer #(
  parameter int WIDTH = 24
) (
  input  logic                i_clk_25MHz,
  input  logic                i_reset_n,
  us_event_timer_if.slave     bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] period_q;
  logic             periodic_q;
  logic             busy_q;
  logic             expired_q;
  logic             pending_q;
  logic             overrun_q;

  logic             final_tick_d;
  logic             fire_d;
  logic             start_zero_d;

  assign final_tick_d = (remaining_q == WIDTH'(1));
  assign start_zero_d = (bus.i_period == '0);
  // Expiry only on an uninterrupted final tick; stop and restart both mask it.
  assign fire_d = (state_q == RUN) && !bus.i_stop && !bus.i_start &&
                  bus.i_tick_1us && final_tick_d;

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      period_q    <= '0;
      periodic_q  <= 1'b0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      expired_q <= fire_d;
      pending_q <= fire_d | (pending_q & ~bus.i_ack);
      // A coincident ack clears overrun even though the new expiry re-arms pending.
      overrun_q <= bus.i_ack ? 1'b0 : (overrun_q | (fire_d & pending_q));

      case (state_q)
        IDLE: begin
          if (!bus.i_stop && bus.i_start && !start_zero_d) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            remaining_q <= bus.i_period;
            period_q    <= bus.i_period;
            periodic_q  <= bus.i_periodic;
          end
        end
        RUN: begin
          if (bus.i_stop || (bus.i_start && start_zero_d)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
          end else if (bus.i_start) begin
            remaining_q <= bus.i_period;
            period_q    <= bus.i_period;
            periodic_q  <= bus.i_periodic;
          end else if (bus.i_tick_1us) begin
            if (final_tick_d) begin
              if (periodic_q) begin
                remaining_q <= period_q;
              end else begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                remaining_q <= '0;
              end
            end else if (remaining_q != '0) begin
              remaining_q <= remaining_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          remaining_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_expired   = expired_q;
  assign bus.o_pending   = pending_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_remaining = remaining_q;

endmodule
